riscv_perf_monitor: RTL and testbench
=====================================

# riscv_perf_monitor

Parametrised performance and run-control monitor for the RISCVCPU matrix-multiply system. It replaces the CPU's fixed 16-bit `clock_count`/`instr_cnt` outputs with configurable-width cycle, retired-instruction and per-channel event counters. It also adds a hardware timeout watchdog, overflow flags and a registered readout port. It sits beside the CPU core, is driven by its retire and `done` strobes, and is read by the bench or by a debug bus.

## Interface
- `CNT_W`, 16, width of every counter.
- `NUM_EVT`, 2, number of extra event channels (1..14).
- `TIMEOUT`, 5000, cycle limit in RUN before the watchdog fires; must be less than 2^CNT_W.
- `CLOCK_50` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse that begins a measurement run.
- `instr_retire` in 1: high for one cycle per retired instruction.
- `evt` in NUM_EVT: per-channel event strobes, one count per high cycle.
- `done` in 1: CPU program-complete indication, level or pulse.
- `rd_sel` in 4: readout select.
- `rd_data` out CNT_W: registered readout of the selected counter.
- `clock_count` out CNT_W: live cycle counter.
- `instr_cnt` out CNT_W: live retired-instruction counter.
- `running` out 1: high while in RUN.
- `finished` out 1: high in DONE.
- `timeout` out 1: high in TIMEDOUT.
- `overflow` out 2+NUM_EVT: sticky per-counter overflow flags. Bit 0 is cycles, bit 1 is instructions, bit 2+k is `evt[k]`.

## Operation
- **States:** IDLE, RUN, DONE, TIMEDOUT.
- **Reset:** state IDLE; all counters, `rd_data`, `overflow`, `running`, `finished` and `timeout` are 0. This applies equally when reset arrives mid-run.
- **IDLE:**
  - `start` → RUN; all counters and `overflow` clear on the same edge.
  - `done` is ignored in IDLE.
- **RUN:**
  - Every cycle: `clock_count` += 1.
  - `instr_cnt` += 1 when `instr_retire` is high.
  - Event counter k += 1 when `evt[k]` is high.
  - `done` high → DONE. The cycle in which `done` is sampled is counted, including any strobe in that cycle.
  - If `clock_count` would become TIMEOUT this cycle → TIMEDOUT. That final increment is applied.
  - If `done` and the timeout condition occur in the same cycle, DONE wins.
  - `start` during RUN is ignored; counts are not disturbed.
- **DONE / TIMEDOUT:**
  - All counters freeze and strobes are ignored.
  - `start` → RUN with counters and `overflow` cleared.
  - `done` in DONE has no effect.
- **Counter arithmetic:** unsigned CNT_W. On an increment from all-ones, the counter's `overflow` bit sets and stays set until the next `start` or `reset`. Wrap or saturate behaviour is set by the macro in Configuration.
- **Readout (`rd_sel`):**
  - 0 → cycles.
  - 1 → instructions.
  - 2..NUM_EVT+1 → event counters.
  - Any other value → 0.
  - Readout is valid in every state.

## Timing
- Counters and status outputs are registered and update on the `CLOCK_50` edge that samples the stimulus.
- `running` rises one cycle after `start` is sampled.
- `clock_count` reads 1 at the end of the first RUN cycle.
- `rd_data` has 1-cycle latency: `rd_sel` sampled at edge n appears after edge n, showing the counter value held before that edge.
- `finished` and `timeout` assert on the edge that takes the transition. They are mutually exclusive and each stays high until `start` or `reset`.
- Synchronous `reset` overrides `start` in the same cycle.

## Configuration
- `PERF_MON_SATURATE_EN` defined: counters saturate at all-ones, so once a counter reaches all-ones its value holds there. The overflow bit sets on the first increment attempted at all-ones.
- Macro undefined: counters wrap to 0 on that increment. The overflow bit sets identically.
- Either way, wrap or saturation of `clock_count` never triggers the timeout; a TIMEOUT less than 2^CNT_W guarantees this.

## Test plan
- Reset for 2 cycles, then no `start` for 20 cycles → all outputs 0, state IDLE, `done` pulses ignored.
- `start`, assert `instr_retire` on 7 of the cycles, `done` on RUN cycle 12 → `clock_count`=12, `instr_cnt`=7, `finished`=1, values frozen for 50 further cycles. Then `rd_sel`=1 → `rd_data`=7 one cycle later.
- TIMEOUT=20, `start`, never `done` → `timeout`=1, `clock_count`=20, `running`=0. A second `start` → counters cleared and RUN again.
- CNT_W=4, `start`, `instr_retire` tied high, `done` after 18 cycles → with the macro: `instr_cnt`=15 and `overflow`[1]=1; without the macro: `instr_cnt`=2 and `overflow`[1]=1.
- `done` and the timeout condition in the same cycle (TIMEOUT=10, `done` on cycle 10) → `finished`=1, `timeout`=0, `clock_count`=10. Separately, `reset` at RUN cycle 5 → everything 0, IDLE.
- NUM_EVT=2, `evt`=2'b01 for 3 cycles and 2'b11 for 2 cycles, then `done` → `rd_sel`=2 returns 5, `rd_sel`=3 returns 2, `rd_sel`=9 returns 0.

Source files
------------

// File: rtl/riscv_perf_monitor.sv
// Cycle / retired-instruction / event counters with a run-control FSM, watchdog and registered readout.
// Define PERF_MON_SATURATE_EN to make counters saturate at all-ones instead of wrapping.
module riscv_perf_monitor #(
    parameter int CNT_W   = 16,
    parameter int NUM_EVT = 2,
    parameter int TIMEOUT = 5000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    input  logic               instr_retire,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               done,
    input  logic [3:0]         rd_sel,
    output logic [CNT_W-1:0]   rd_data,
    output logic [CNT_W-1:0]   clock_count,
    output logic [CNT_W-1:0]   instr_cnt,
    output logic               running,
    output logic               finished,
    output logic               timeout,
    output logic [NUM_EVT+1:0] overflow,
    output logic [1:0]         state_dbg
);

    localparam int NUM_CNT = NUM_EVT + 2;
    // A TIMEOUT the cycle counter can never reach leaves the watchdog inert.
    localparam bit TO_EN = (TIMEOUT > 0) && ((CNT_W >= 31) || (TIMEOUT < (1 << CNT_W)));
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        DONE     = 2'd2,
        TIMEDOUT = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   clr;
    logic   count_en;

    logic [CNT_W-1:0]   cnt_q [NUM_CNT];
    logic [NUM_CNT-1:0] ovf_q;
    logic [NUM_CNT-1:0] inc;
    logic [CNT_W-1:0]   rd_next;
    logic               timeout_hit;

    assign inc         = {evt, instr_retire, 1'b1};
    assign timeout_hit = TO_EN && (cnt_q[0] == TO_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        clr      = 1'b0;
        count_en = 1'b0;
        case (state_q)
            IDLE, DONE, TIMEDOUT: begin
                if (start) begin
                    state_d = RUN;
                    clr     = 1'b1;
                end
            end
            RUN: begin
                count_en = 1'b1;
                // done takes priority over a simultaneous watchdog expiry
                if (done) begin
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = TIMEDOUT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset || clr) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else if (count_en) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (inc[i]) begin
                    if (&cnt_q[i]) begin
                        ovf_q[i] <= 1'b1;
`ifdef PERF_MON_SATURATE_EN
                        cnt_q[i] <= cnt_q[i];
`else
                        cnt_q[i] <= '0;
`endif
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_sel == 4'(i)) begin
                rd_next = cnt_q[i];
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

    assign clock_count = cnt_q[0];
    assign instr_cnt   = cnt_q[1];
    assign overflow    = ovf_q;
    assign running     = (state_q == RUN);
    assign finished    = (state_q == DONE);
    assign timeout     = (state_q == TIMEDOUT);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_riscv_perf_monitor.sv
// Directed bench for riscv_perf_monitor: three instances (watchdog 20, watchdog 10 with 4-bit counters,
// 4-bit counters with watchdog out of range) share one stimulus stream.
module tb_riscv_perf_monitor;

    logic       clk = 1'b0;
    logic       reset, start, instr_retire, done;
    logic [1:0] evt;
    logic [3:0] rd_sel;

    logic [15:0] a_rd, a_clk, a_ins;
    logic        a_run, a_fin, a_to;
    logic [3:0]  a_ovf;
    logic [1:0]  a_st;

    logic [3:0]  b_rd, b_clk, b_ins;
    logic        b_run, b_fin, b_to;
    logic [3:0]  b_ovf;
    logic [1:0]  b_st;

    logic [3:0]  c_rd, c_clk, c_ins;
    logic        c_run, c_fin, c_to;
    logic [3:0]  c_ovf;
    logic [1:0]  c_st;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_perf_monitor #(.CNT_W(16), .NUM_EVT(2), .TIMEOUT(20)) dut_a (
        .CLOCK_50(clk), .reset(reset), .start(start), .instr_retire(instr_retire), .evt(evt),
        .done(done), .rd_sel(rd_sel), .rd_data(a_rd), .clock_count(a_clk), .instr_cnt(a_ins),
        .running(a_run), .finished(a_fin), .timeout(a_to), .overflow(a_ovf), .state_dbg(a_st));

    riscv_perf_monitor #(.CNT_W(4), .NUM_EVT(2), .TIMEOUT(10)) dut_b (
        .CLOCK_50(clk), .reset(reset), .start(start), .instr_retire(instr_retire), .evt(evt),
        .done(done), .rd_sel(rd_sel), .rd_data(b_rd), .clock_count(b_clk), .instr_cnt(b_ins),
        .running(b_run), .finished(b_fin), .timeout(b_to), .overflow(b_ovf), .state_dbg(b_st));

    riscv_perf_monitor #(.CNT_W(4), .NUM_EVT(2), .TIMEOUT(5000)) dut_c (
        .CLOCK_50(clk), .reset(reset), .start(start), .instr_retire(instr_retire), .evt(evt),
        .done(done), .rd_sel(rd_sel), .rd_data(c_rd), .clock_count(c_clk), .instr_cnt(c_ins),
        .running(c_run), .finished(c_fin), .timeout(c_to), .overflow(c_ovf), .state_dbg(c_st));

    typedef struct {
        logic        start;
        logic        instr;
        logic        done;
        logic [15:0] exp_clk;
        logic [15:0] exp_ins;
        logic        exp_run;
        logic        exp_fin;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; instr_retire = 1'b0; done = 1'b0; evt = 2'b00; rd_sel = 4'd0;

        // run with done on cycle 12; retire on cycles 1,2,4,5,7,9,12; rd_sel=0 shows previous clock
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'd0,  16'd0, 1'b1, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'd1,  16'd1, 1'b1, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'd2,  16'd2, 1'b1, 1'b0, 16'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'd3,  16'd2, 1'b1, 1'b0, 16'd2};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'd4,  16'd3, 1'b1, 1'b0, 16'd3};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'd5,  16'd4, 1'b1, 1'b0, 16'd4};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'd6,  16'd4, 1'b1, 1'b0, 16'd5};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'd7,  16'd5, 1'b1, 1'b0, 16'd6};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'd8,  16'd5, 1'b1, 1'b0, 16'd7};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'd9,  16'd6, 1'b1, 1'b0, 16'd8};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'd10, 16'd6, 1'b1, 1'b0, 16'd9};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 16'd11, 16'd6, 1'b1, 1'b0, 16'd10};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 16'd12, 16'd7, 1'b0, 1'b1, 16'd11};

        // reset, then idle with done pulses and strobes that must be ignored
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            done = (i % 5 == 0); instr_retire = 1'b1; evt = 2'b11;
            step();
        end
        done = 1'b0; instr_retire = 1'b0; evt = 2'b00;
        chk("idle_clock", a_clk, 0);
        chk("idle_instr", a_ins, 0);
        chk("idle_flags", {a_run, a_fin, a_to}, 0);
        chk("idle_overflow", a_ovf, 0);
        chk("idle_state", a_st, 0);
        chk("idle_rd", a_rd, 0);

        for (int i = 0; i < 13; i++) begin
            start = vecs[i].start; instr_retire = vecs[i].instr; done = vecs[i].done; rd_sel = 4'd0;
            step();
            chk($sformatf("v%0d_clock", i), a_clk, vecs[i].exp_clk);
            chk($sformatf("v%0d_instr", i), a_ins, vecs[i].exp_ins);
            chk($sformatf("v%0d_running", i), a_run, vecs[i].exp_run);
            chk($sformatf("v%0d_finished", i), a_fin, vecs[i].exp_fin);
            chk($sformatf("v%0d_rd", i), a_rd, vecs[i].exp_rd);
        end
        start = 1'b0; done = 1'b0;

        // frozen in DONE despite strobes and done toggling
        for (int i = 0; i < 50; i++) begin
            instr_retire = 1'b1; evt = 2'b11; done = i[0];
            step();
        end
        instr_retire = 1'b0; evt = 2'b00; done = 1'b0;
        chk("frozen_clock", a_clk, 12);
        chk("frozen_instr", a_ins, 7);
        chk("frozen_finished", a_fin, 1);
        chk("frozen_rd_cycles", a_rd, 12);
        rd_sel = 4'd1;
        step();
        chk("rd_instr", a_rd, 7);

        // watchdog: dut_a at 20 cycles, dut_b at 10; a start mid-run is ignored
        rd_sel = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 19; i++) begin
            start = (i == 7);
            step();
        end
        start = 1'b0;
        chk("to_pre_clock", a_clk, 19);
        chk("to_pre_flags", {a_run, a_fin, a_to}, 3'b100);
        step();
        chk("to_clock", a_clk, 20);
        chk("to_flags", {a_run, a_fin, a_to}, 3'b001);
        chk("to_b_clock", b_clk, 10);
        chk("to_b_flags", {b_run, b_fin, b_to}, 3'b001);
        for (int i = 0; i < 5; i++) step();
        chk("to_frozen_clock", a_clk, 20);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_clock", a_clk, 0);
        chk("restart_flags", {a_run, a_fin, a_to}, 3'b100);

        // reset mid-run, with start in the same cycle
        for (int i = 0; i < 5; i++) step();
        chk("pre_reset_clock", a_clk, 5);
        reset = 1'b1; start = 1'b1;
        step();
        reset = 1'b0; start = 1'b0;
        chk("reset_clock", a_clk, 0);
        chk("reset_flags", {a_run, a_fin, a_to}, 0);
        chk("reset_state", a_st, 0);
        chk("reset_rd", a_rd, 0);
        step();
        chk("post_reset_running", a_run, 0);

        // event channels
        start = 1'b1;
        step();
        start = 1'b0;
        evt = 2'b01; step(); step(); step();
        evt = 2'b11; step(); step();
        evt = 2'b00; done = 1'b1;
        step();
        done = 1'b0;
        chk("evt_clock", a_clk, 6);
        rd_sel = 4'd2; step(); chk("rd_evt0", a_rd, 5);
        rd_sel = 4'd3; step(); chk("rd_evt1", a_rd, 2);
        rd_sel = 4'd9; step(); chk("rd_sel9", a_rd, 0);
        rd_sel = 4'd4; step(); chk("rd_sel4", a_rd, 0);
        rd_sel = 4'd0; step(); chk("rd_sel0", a_rd, 6);

        // done and watchdog in the same cycle on dut_b
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            done = (i == 10);
            step();
        end
        done = 1'b0;
        chk("tie_b_clock", b_clk, 10);
        chk("tie_b_flags", {b_run, b_fin, b_to}, 3'b010);
        chk("tie_a_clock", a_clk, 10);

        // 4-bit overflow on dut_c, done on cycle 18
        start = 1'b1;
        step();
        start = 1'b0; instr_retire = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            done = (i == 18);
            step();
            if (i == 15) begin
                chk("ovf_pre_instr", c_ins, 15);
                chk("ovf_pre_flags", c_ovf, 0);
            end
            if (i == 16) begin
`ifdef PERF_MON_SATURATE_EN
                chk("ovf_edge_instr", c_ins, 15);
`else
                chk("ovf_edge_instr", c_ins, 0);
`endif
                chk("ovf_edge_flags", c_ovf, 4'b0011);
            end
        end
        done = 1'b0;
`ifdef PERF_MON_SATURATE_EN
        chk("ovf_instr", c_ins, 15);
        chk("ovf_clock", c_clk, 15);
`else
        chk("ovf_instr", c_ins, 2);
        chk("ovf_clock", c_clk, 2);
`endif
        chk("ovf_flags", c_ovf, 4'b0011);
        chk("ovf_finished", c_fin, 1);
        chk("ovf_a_instr", a_ins, 18);
        step();
        instr_retire = 1'b0;
        chk("ovf_sticky", c_ovf, 4'b0011);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ovf_cleared", c_ovf, 0);
        chk("ovf_cleared_instr", c_ins, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
